// File: rtl/alu_mc_if.sv
// Handshake and result bundle for the multi-cycle ALU. The master drives
// operations and consumes results; the ALU itself sits on the slave modport.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       aluop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res_low;
    logic [WIDTH-1:0] res_high;
    logic             zero;
    logic             sign;
    logic             div_by_zero;

    modport master (
        output flush, in_valid, aluop, a, b, out_ready,
        input  in_ready, out_valid, res_low, res_high, zero, sign, div_by_zero
    );

    modport slave (
        input  flush, in_valid, aluop, a, b, out_ready,
        output in_ready, out_valid, res_low, res_high, zero, sign, div_by_zero
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle logic/shift ops, iterative shift-add
// multiply and restoring divide. Define ALU_MC_SIGNED_MULDIV_EN for signed mul/div.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic    clk,
    input  logic    rst_n,
    alu_mc_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MULU = 4'd2;
    localparam logic [3:0] OP_DIVU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;
    localparam logic [3:0] OP_ROTR = 4'd12;
    localparam int         CW      = SHW + 2;
    localparam logic [CW-1:0] CNT_STEPS = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic             accept, in_ready_c, out_valid_c;
    logic             in_mul, is_mul, is_div, iter_op, last_cycle;
    logic [WIDTH-1:0] a_in, b_in;
    logic [3:0]       op_p0;
    logic [WIDTH-1:0] a_p0, b_p0;
    logic [WIDTH-1:0] hi_p1, lo_p1;
    logic [CW-1:0]    count_p1;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] res_low, res_high;
    logic             dbz;

`ifdef ALU_MC_SIGNED_MULDIV_EN
    localparam logic [3:0]    OP_MUL  = 4'd7;
    localparam logic [3:0]    OP_DIV  = 4'd8;
    localparam logic [CW-1:0] CNT_FIX = CW'(WIDTH + 1);

    logic               in_signed, is_signed, neg_a_p0, neg_b_p0;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    function automatic logic [WIDTH-1:0] cond_neg(input logic signed [WIDTH-1:0] x,
                                                  input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic signed [2*WIDTH-1:0] x,
                                                     input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
        return cond_neg(x, x[WIDTH-1]);
    endfunction

    assign in_signed  = (bus.aluop == OP_MUL) || (bus.aluop == OP_DIV);
    assign is_signed  = (op_p0 == OP_MUL) || (op_p0 == OP_DIV);
    assign in_mul     = (bus.aluop == OP_MULU) || (bus.aluop == OP_MUL);
    assign is_mul     = (op_p0 == OP_MULU) || (op_p0 == OP_MUL);
    assign is_div     = (op_p0 == OP_DIVU) || (op_p0 == OP_DIV);
    assign a_in       = in_signed ? magnitude(bus.a) : bus.a;
    assign b_in       = in_signed ? magnitude(bus.b) : bus.b;
    assign last_cycle = !iter_op || (count_p1 == (is_signed ? CNT_FIX : CNT_STEPS));

    // Divide-by-zero keeps the all-ones quotient; the remainder |a| regains a's sign.
    assign prod_fix = cond_neg2({hi_p1, lo_p1}, neg_a_p0 ^ neg_b_p0);
    assign quo_fix  = (b_p0 == '0) ? lo_p1 : cond_neg(lo_p1, neg_a_p0 ^ neg_b_p0);
    assign rem_fix  = cond_neg(hi_p1, neg_a_p0);
`else
    assign in_mul     = (bus.aluop == OP_MULU);
    assign is_mul     = (op_p0 == OP_MULU);
    assign is_div     = (op_p0 == OP_DIVU);
    assign a_in       = bus.a;
    assign b_in       = bus.b;
    assign last_cycle = !iter_op || (count_p1 == CNT_STEPS);
`endif

    assign iter_op = is_mul || is_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && !bus.flush) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN:  if (last_cycle) state_nxt = DONE;
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    assign sh        = b_p0[SHW-1:0];
    assign mul_sum   = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, a_p0} : '0);
    assign div_shift = {hi_p1, lo_p1[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_p0};
    assign div_diff  = div_shift[WIDTH-1:0] - b_p0;

    always_comb begin
        alu_res = '0;
        case (op_p0)
            OP_ADD:  alu_res = a_p0 + b_p0;
            OP_SUB:  alu_res = a_p0 - b_p0;
            OP_AND:  alu_res = a_p0 & b_p0;
            OP_OR:   alu_res = a_p0 | b_p0;
            OP_XOR:  alu_res = a_p0 ^ b_p0;
            OP_SLL:  alu_res = a_p0 << sh;
            OP_SRL:  alu_res = a_p0 >> sh;
            OP_SRA:  alu_res = $signed(a_p0) >>> sh;
            OP_ROTR: alu_res = (a_p0 >> sh) | (a_p0 << (WIDTH - int'(sh)));
            default: alu_res = '0;
        endcase
    end

    // p0: operands latched on accept; p1: iterative hi/lo datapath.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0    <= bus.aluop;
            a_p0     <= a_in;
            b_p0     <= b_in;
`ifdef ALU_MC_SIGNED_MULDIV_EN
            neg_a_p0 <= in_signed && bus.a[WIDTH-1];
            neg_b_p0 <= in_signed && bus.b[WIDTH-1];
`endif
            hi_p1    <= '0;
            lo_p1    <= in_mul ? b_in : a_in;
            count_p1 <= '0;
        end else if (state == RUN && iter_op) begin
            if (count_p1 < CNT_STEPS) begin
                count_p1 <= count_p1 + CW'(1);
                if (is_mul) begin
                    hi_p1 <= mul_sum[WIDTH:1];
                    lo_p1 <= {mul_sum[0], lo_p1[WIDTH-1:1]};
                end else begin
                    hi_p1 <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                    lo_p1 <= {lo_p1[WIDTH-2:0], div_ge};
                end
            end
`ifdef ALU_MC_SIGNED_MULDIV_EN
            else if (is_signed && count_p1 == CNT_STEPS) begin
                count_p1 <= count_p1 + CW'(1);
                if (is_mul) begin
                    {hi_p1, lo_p1} <= prod_fix;
                end else begin
                    hi_p1 <= rem_fix;
                    lo_p1 <= quo_fix;
                end
            end
`endif
        end
    end

    // Result registers: written on entry to DONE, held until the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_low  <= '0;
            res_high <= '0;
            dbz      <= 1'b0;
        end else if (bus.flush) begin
            dbz <= 1'b0;
        end else if (state == RUN && last_cycle) begin
            res_low  <= iter_op ? lo_p1 : alu_res;
            res_high <= iter_op ? hi_p1 : '0;
            dbz      <= is_div && (b_p0 == '0);
        end else if (state == DONE && bus.out_ready) begin
            dbz <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_c;
    assign bus.res_low     = res_low;
    assign bus.res_high    = res_high;
    assign bus.zero        = out_valid_c && (res_low == '0);
    assign bus.sign        = out_valid_c && res_low[WIDTH-1];
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32) with an arithmetic reference model and
// a per-cycle result checker.
module tb_alu_mc;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_lo = '0;
    logic [31:0] exp_hi = '0;
    logic        exp_dz = 1'b0;

    alu_mc_if #(.WIDTH(W)) bus ();
    alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [31:0] x, y,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic dz);
        logic [63:0] p;
        int sh;
        sh = int'(y[4:0]);
        lo = '0; hi = '0; dz = 1'b0;
        case (op)
            4'd0: lo = x + y;
            4'd1: lo = x - y;
            4'd2: begin p = {32'd0, x} * {32'd0, y}; lo = p[31:0]; hi = p[63:32]; end
            4'd3: if (y == 0) begin lo = '1; hi = x; dz = 1'b1; end
                  else begin lo = x / y; hi = x % y; end
            4'd4: lo = x & y;
            4'd5: lo = x | y;
            4'd6: lo = x ^ y;
            4'd9:  lo = x << sh;
            4'd10: lo = x >> sh;
            4'd11: lo = $signed(x) >>> sh;
            4'd12: lo = (sh == 0) ? x : ((x >> sh) | (x << (32 - sh)));
`ifdef ALU_MC_SIGNED_MULDIV_EN
            4'd7: begin
                p  = 64'(longint'($signed(x)) * longint'($signed(y)));
                lo = p[31:0]; hi = p[63:32];
            end
            4'd8: if (y == 0) begin lo = '1; hi = x; dz = 1'b1; end
                  else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin lo = x; hi = '0; end
                  else begin lo = $signed(x) / $signed(y); hi = $signed(x) % $signed(y); end
`endif
            default: ;
        endcase
    endfunction

    function automatic int lat(input logic [3:0] op);
        if (op == 4'd2 || op == 4'd3) return W + 1;
`ifdef ALU_MC_SIGNED_MULDIV_EN
        if (op == 4'd7 || op == 4'd8) return W + 2;
`endif
        return 1;
    endfunction

    // Result checker: every negedge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                check("res_low", bus.res_low, exp_lo);
                check("res_high", bus.res_high, exp_hi);
                check("zero", bus.zero, exp_lo == 0);
                check("sign", bus.sign, exp_lo[31]);
                check("div_by_zero", bus.div_by_zero, exp_dz);
            end else begin
                check("idle_flags", {bus.zero, bus.sign, bus.div_by_zero}, 3'b000);
            end
        end
    end

    task automatic release_res();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("release_valid", bus.out_valid, 0);
        check("release_ready", bus.in_ready, 1);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input bit rel);
        int cnt;
        bit busy_ok;
        @(negedge clk);
        bus.aluop = op; bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
        check("accept_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.aluop = 4'($urandom);
        model(op, av, bv, exp_lo, exp_hi, exp_dz);
        cnt = 0; busy_ok = 1'b1;
        while (!bus.out_valid && cnt < 100) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", 64'(cnt), 64'(lat(op)));
        check("busy_in_ready", busy_ok, 1);
        if (rel) release_res();
    endtask

    logic [3:0]  t_op [14] = '{4'd4, 4'd5, 4'd9, 4'd10, 4'd12, 4'd12, 4'd13,
                               4'd7, 4'd2, 4'd3, 4'd1, 4'd0, 4'd11, 4'd3};
    logic [31:0] t_a  [14] = '{32'hF0F01234, 32'hF0000000, 32'h3, 32'h80000000,
                               32'h12345678, 32'h12345678, 32'hFFFFFFFF, 32'h3,
                               32'h12345678, 32'h5, 32'h0, 32'hFFFFFFFF,
                               32'h7FFFFFF0, 32'hFFFFFFFF};
    logic [31:0] t_b  [14] = '{32'h0FF0FF00, 32'h0000000F, 32'h21, 32'h4,
                               32'h20, 32'h4, 32'hFFFFFFFF, 32'h5,
                               32'h9ABCDEF0, 32'h9, 32'h1, 32'h1,
                               32'h4, 32'h1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held;
        bit stable, blocked, rose;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.aluop = '0; bus.a = '0; bus.b = '0;
        #2;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_res", {bus.res_low, bus.res_high}, 64'd0);
        check("rst_flags", {bus.zero, bus.sign, bus.div_by_zero}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd0, 32'h7FFFFFFF, 32'h1, 1'b0);
        check("lit_add_lo", bus.res_low, 32'h80000000);
        check("lit_add_hi", bus.res_high, 32'h0);
        check("lit_add_flags", {bus.sign, bus.zero}, 2'b10);
        release_res();
        run_op(4'd1, 32'h5, 32'h5, 1'b0);
        check("lit_sub", {bus.res_low, 31'd0, bus.zero}, 64'd1);
        release_res();
        run_op(4'd11, 32'h80000000, 32'h1F, 1'b0);
        check("lit_sra", bus.res_low, 32'hFFFFFFFF);
        release_res();
        run_op(4'd12, 32'h1, 32'h1, 1'b0);
        check("lit_rotr", bus.res_low, 32'h80000000);
        release_res();
        run_op(4'd2, 32'hFFFFFFFF, 32'h2, 1'b0);
        check("lit_mulu", {bus.res_high, bus.res_low}, 64'h1_FFFFFFFE);
        release_res();
        run_op(4'd3, 32'd100, 32'd7, 1'b0);
        check("lit_divu", {bus.res_high, bus.res_low}, {32'd2, 32'd14});
        release_res();
        run_op(4'd3, 32'h1234, 32'h0, 1'b0);
        check("lit_div0", {bus.res_high, bus.res_low}, {32'h1234, 32'hFFFFFFFF});
        check("lit_div0_flag", bus.div_by_zero, 1);
        release_res();
        check("div0_flag_cleared", bus.div_by_zero, 0);

        for (int i = 0; i < 14; i++) run_op(t_op[i], t_a[i], t_b[i], 1'b1);

        // Backpressure: result must hold and a new request must wait.
        run_op(4'd6, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0);
        check("lit_xor", bus.res_low, 32'hFF00FF00);
        held = bus.res_low;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.aluop = 4'd0; bus.a = 32'd3; bus.b = 32'd4;
        stable = 1'b1; blocked = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.res_low !== held) stable = 1'b0;
            if (bus.in_ready) blocked = 1'b0;
        end
        check("hold_stable", stable, 1);
        check("hold_blocked", blocked, 1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("pulse_valid", bus.out_valid, 0);
        check("pulse_ready", bus.in_ready, 1);
        model(4'd0, 32'd3, 32'd4, exp_lo, exp_hi, exp_dz);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("second_valid", bus.out_valid, 1);
        check("second_res", bus.res_low, 32'd7);
        release_res();

        // Flush five cycles into a divide.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.aluop = 4'd3; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_ready", bus.in_ready, 1);
        check("flush_valid", bus.out_valid, 0);
        rose = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) rose = 1'b1;
        end
        check("flush_no_result", rose, 0);

        // Flush wins over a request in IDLE.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.flush = 1'b1; bus.aluop = 4'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        rose = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.out_valid || !bus.in_ready) rose = 1'b1;
        end
        check("flush_idle_reject", rose, 0);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.aluop = 4'd2; bus.a = 32'd3; bus.b = 32'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_res", {bus.res_high, bus.res_low}, 64'd0);
        check("arst_flags", {bus.zero, bus.sign, bus.div_by_zero}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        rose = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) rose = 1'b1;
        end
        check("arst_abandoned", rose, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
